// File: rtl/time_entry_to_number.sv
// Keypad time entry: collects six BCD digits (HH MM SS), validates each against its
// position, and on completion loads binary hour/min/sec into the clock counter.
module time_entry_to_number #(
   parameter bit HOUR24 = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        cancel,
   input  logic        digit_valid,
   input  logic [3:0]  digit,
   output logic [4:0]  hour,
   output logic [5:0]  min,
   output logic [5:0]  sec,
   output logic        load,
   output logic        busy,
   output logic        err,
   output logic [2:0]  pos,
   output logic [23:0] entry_digits
);

   // Inputs are single-cycle pulses with no back-pressure: a digit_valid pulse is
   // consumed in the cycle it appears, either stored or flagged by err next cycle.
   typedef enum logic [1:0] {IDLE, ENTRY, COMMIT} state_t;

   localparam logic [23:0] BLANK = 24'hFFFFFF;

   state_t      state, state_nxt;
   logic [4:0]  hour_nxt;
   logic [5:0]  min_nxt, sec_nxt;
   logic        load_nxt, busy_nxt, err_nxt;
   logic [2:0]  pos_nxt;
   logic [23:0] entry_nxt;
   logic        accept;
   logic [3:0]  h_tens;

   assign h_tens = entry_digits[23:20];

   always_comb begin
      accept = 1'b0;
      if (digit <= 4'd9) begin
         case (pos)
            3'd0: accept = HOUR24 ? (digit <= 4'd2) : (digit <= 4'd1);
            3'd1: begin
               if (HOUR24) accept = (h_tens == 4'd2) ? (digit <= 4'd3) : 1'b1;
               else        accept = (h_tens == 4'd0) ? (digit != 4'd0) : (digit <= 4'd2);
            end
            3'd2, 3'd4: accept = (digit <= 4'd5);
            3'd3, 3'd5: accept = 1'b1;
            default:    accept = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      hour_nxt  = hour;
      min_nxt   = min;
      sec_nxt   = sec;
      load_nxt  = 1'b0;
      err_nxt   = 1'b0;
      pos_nxt   = pos;
      entry_nxt = entry_digits;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = ENTRY;
               pos_nxt   = 3'd0;
               entry_nxt = BLANK;
            end
         end
         ENTRY: begin
            if (cancel) begin
               state_nxt = IDLE;
               pos_nxt   = 3'd0;
               entry_nxt = BLANK;
            end else if (start) begin
               pos_nxt   = 3'd0;
               entry_nxt = BLANK;
            end else if (digit_valid) begin
               if (accept) begin
                  for (int i = 0; i < 6; i++) begin
                     if (pos == 3'(i)) entry_nxt[20-4*i +: 4] = digit;
                  end
                  // pos stays at 5 while committing; it never points past the last slot
                  if (pos == 3'd5) state_nxt = COMMIT;
                  else             pos_nxt   = pos + 3'd1;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         COMMIT: begin
            // First COMMIT cycle raises load with the converted time; the second returns to IDLE
            if (!load) begin
               load_nxt = 1'b1;
               hour_nxt = 5'(entry_digits[23:20]) * 5'd10 + 5'(entry_digits[19:16]);
               min_nxt  = 6'(entry_digits[15:12]) * 6'd10 + 6'(entry_digits[11:8]);
               sec_nxt  = 6'(entry_digits[7:4])   * 6'd10 + 6'(entry_digits[3:0]);
            end else begin
               state_nxt = IDLE;
               pos_nxt   = 3'd0;
               entry_nxt = BLANK;
            end
         end
         default: begin
            state_nxt = IDLE;
            pos_nxt   = 3'd0;
            entry_nxt = BLANK;
         end
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hour         <= 5'd0;
         min          <= 6'd0;
         sec          <= 6'd0;
         load         <= 1'b0;
         busy         <= 1'b0;
         err          <= 1'b0;
         pos          <= 3'd0;
         entry_digits <= BLANK;
      end else begin
         hour         <= hour_nxt;
         min          <= min_nxt;
         sec          <= sec_nxt;
         load         <= load_nxt;
         busy         <= busy_nxt;
         err          <= err_nxt;
         pos          <= pos_nxt;
         entry_digits <= entry_nxt;
      end
   end

endmodule

// File: tb/tb_time_entry_to_number.sv
// Bench for time_entry_to_number: 24 h and 12 h instances share stimulus and are
// checked every cycle against a digit-list reference model.
module tb_time_entry_to_number;

   logic       clk, rst, start, cancel, digit_valid;
   logic [3:0] digit;

   logic [4:0]  hour_w [2];
   logic [5:0]  min_w  [2];
   logic [5:0]  sec_w  [2];
   logic        load_w [2];
   logic        busy_w [2];
   logic        err_w  [2];
   logic [2:0]  pos_w  [2];
   logic [23:0] ed_w   [2];

   time_entry_to_number #(.HOUR24(1'b1)) u24 (
      .clk(clk), .rst(rst), .start(start), .cancel(cancel),
      .digit_valid(digit_valid), .digit(digit),
      .hour(hour_w[0]), .min(min_w[0]), .sec(sec_w[0]), .load(load_w[0]),
      .busy(busy_w[0]), .err(err_w[0]), .pos(pos_w[0]), .entry_digits(ed_w[0])
   );

   time_entry_to_number #(.HOUR24(1'b0)) u12 (
      .clk(clk), .rst(rst), .start(start), .cancel(cancel),
      .digit_valid(digit_valid), .digit(digit),
      .hour(hour_w[1]), .min(min_w[1]), .sec(sec_w[1]), .load(load_w[1]),
      .busy(busy_w[1]), .err(err_w[1]), .pos(pos_w[1]), .entry_digits(ed_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
   endtask

   // Reference model: phase 0 idle, 1 entering, 2 digits complete, 3 load shown
   int m_phase [2];
   int m_cnt   [2];
   int m_dig   [2][6];
   int m_hour  [2];
   int m_min   [2];
   int m_sec   [2];
   int m_load  [2];
   int m_err   [2];

   function automatic bit digit_ok(int inst, int p, int tens, int d);
      int max_h, min_h, v;
      max_h = (inst == 0) ? 23 : 12;
      min_h = (inst == 0) ? 0 : 1;
      if (d > 9) return 1'b0;
      case (p)
         0: return (d * 10 <= max_h);
         1: begin
            v = tens * 10 + d;
            return (v >= min_h) && (v <= max_h);
         end
         2, 4: return (d * 10 <= 59);
         default: return 1'b1;
      endcase
   endfunction

   task automatic model_step(int i, bit r, bit s, bit c, bit v, int d);
      if (r) begin
         m_phase[i] = 0; m_cnt[i] = 0; m_hour[i] = 0; m_min[i] = 0; m_sec[i] = 0;
         m_load[i] = 0; m_err[i] = 0;
         return;
      end
      m_load[i] = 0;
      m_err[i]  = 0;
      case (m_phase[i])
         0: if (s) begin m_phase[i] = 1; m_cnt[i] = 0; end
         1: begin
            if (c) begin
               m_phase[i] = 0; m_cnt[i] = 0;
            end else if (s) begin
               m_cnt[i] = 0;
            end else if (v) begin
               if (digit_ok(i, m_cnt[i], (m_cnt[i] > 0) ? m_dig[i][0] : 0, d)) begin
                  m_dig[i][m_cnt[i]] = d;
                  m_cnt[i]++;
                  if (m_cnt[i] == 6) m_phase[i] = 2;
               end else begin
                  m_err[i] = 1;
               end
            end
         end
         2: begin
            m_phase[i] = 3;
            m_load[i]  = 1;
            m_hour[i]  = m_dig[i][0] * 10 + m_dig[i][1];
            m_min[i]   = m_dig[i][2] * 10 + m_dig[i][3];
            m_sec[i]   = m_dig[i][4] * 10 + m_dig[i][5];
         end
         default: begin m_phase[i] = 0; m_cnt[i] = 0; end
      endcase
   endtask

   function automatic logic [23:0] exp_entry(int i);
      logic [23:0] ed;
      int dv;
      ed = 24'hFFFFFF;
      if (m_phase[i] != 0) begin
         for (int k = 0; k < m_cnt[i]; k++) begin
            dv = m_dig[i][k];
            ed[20-4*k +: 4] = dv[3:0];
         end
      end
      return ed;
   endfunction

   task automatic compare_all();
      string nm;
      int    ep;
      for (int i = 0; i < 2; i++) begin
         nm = (i == 0) ? "u24" : "u12";
         ep = (m_phase[i] == 0) ? 0 : ((m_cnt[i] > 5) ? 5 : m_cnt[i]);
         check({nm, ".hour"},  32'(hour_w[i]), 32'(m_hour[i]));
         check({nm, ".min"},   32'(min_w[i]),  32'(m_min[i]));
         check({nm, ".sec"},   32'(sec_w[i]),  32'(m_sec[i]));
         check({nm, ".load"},  32'(load_w[i]), 32'(m_load[i]));
         check({nm, ".err"},   32'(err_w[i]),  32'(m_err[i]));
         check({nm, ".busy"},  32'(busy_w[i]), 32'(m_phase[i] != 0));
         check({nm, ".pos"},   32'(pos_w[i]),  32'(ep));
         check({nm, ".entry"}, 32'(ed_w[i]),   32'(exp_entry(i)));
      end
   endtask

   // Called at a negedge: drive, clock once, update model, sample at the next negedge
   task automatic cycle(input bit r, input bit s, input bit c, input bit v, input int d);
      rst = r; start = s; cancel = c; digit_valid = v; digit = 4'(d);
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_step(i, r, s, c, v, d);
      @(negedge clk);
      compare_all();
      rst = 1'b0; start = 1'b0; cancel = 1'b0; digit_valid = 1'b0; digit = 4'd0;
   endtask

   task automatic key(input int d);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, d);
   endtask

   task automatic idle_cyc();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic begin_entry();
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; cancel = 1'b0; digit_valid = 1'b0; digit = 4'd0;
      @(negedge clk);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
      check("reset_entry", 32'(ed_w[0]), 32'h00FFFFFF);
      check("reset_busy", 32'(busy_w[0]), 32'd0);

      // 13:45:07
      begin_entry();
      key(1); key(3); key(4); key(5); key(0); key(7);
      check("t1_pre_load", 32'(load_w[0]), 32'd0);
      idle_cyc();
      check("t1_load", 32'(load_w[0]), 32'd1);
      check("t1_hour", 32'(hour_w[0]), 32'd13);
      check("t1_min", 32'(min_w[0]), 32'd45);
      check("t1_sec", 32'(sec_w[0]), 32'd7);
      idle_cyc();
      check("t1_idle_busy", 32'(busy_w[0]), 32'd0);
      check("t1_idle_entry", 32'(ed_w[0]), 32'h00FFFFFF);

      // 24 rejected in 24 h, then 23:59:59
      begin_entry();
      key(2); key(4);
      check("t2_err", 32'(err_w[0]), 32'd1);
      check("t2_pos", 32'(pos_w[0]), 32'd1);
      key(3); key(5); key(9); key(5); key(9);
      idle_cyc();
      check("t2_hour", 32'(hour_w[0]), 32'd23);
      check("t2_sec", 32'(sec_w[0]), 32'd59);
      idle_cyc(); idle_cyc();

      // cancel keeps previous time; digits while idle are ignored
      begin_entry();
      key(1); key(2); key(3);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 0);
      check("t3_busy", 32'(busy_w[0]), 32'd0);
      check("t3_hour_kept", 32'(hour_w[0]), 32'd23);
      key(12);
      check("t3_idle_err", 32'(err_w[0]), 32'd0);

      // start together with cancel: cancel wins; then restart mid-entry
      begin_entry();
      key(0); key(9);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 0);
      check("t4_cancel_wins", 32'(busy_w[0]), 32'd0);
      begin_entry();
      key(0); key(9);
      begin_entry();
      check("t4_restart_pos", 32'(pos_w[0]), 32'd0);
      check("t4_restart_entry", 32'(ed_w[0]), 32'h00FFFFFF);

      // 12 h rules
      begin_entry();
      key(0); key(0);
      check("t5_u12_err00", 32'(err_w[1]), 32'd1);
      begin_entry();
      key(1); key(3);
      check("t5_u12_err13", 32'(err_w[1]), 32'd1);
      begin_entry();
      key(1); key(2); key(0); key(0); key(0); key(0);
      idle_cyc();
      check("t5_u12_hour", 32'(hour_w[1]), 32'd12);
      check("t5_u12_load", 32'(load_w[1]), 32'd1);
      idle_cyc(); idle_cyc();

      // illegal digits then reset mid-entry
      begin_entry();
      key(9);
      check("t6_err9", 32'(err_w[0]), 32'd1);
      key(15);
      check("t6_err15_b2b", 32'(err_w[0]), 32'd1);
      key(1); key(2); key(10); key(3); key(4);
      check("t6_pos4", 32'(pos_w[0]), 32'd4);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
      check("t6_rst_hour", 32'(hour_w[0]), 32'd0);
      check("t6_rst_pos", 32'(pos_w[0]), 32'd0);

      // randomized traffic
      for (int n = 0; n < 2000; n++) begin
         int  dsel;
         bit  r, s, c, v;
         r = ($urandom_range(0, 199) == 0);
         s = ($urandom_range(0, 29) == 0);
         c = ($urandom_range(0, 39) == 0);
         v = ($urandom_range(0, 9) < 7);
         dsel = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15))
                                            : int'($urandom_range(0, 9));
         if ($urandom_range(0, 1) == 1 && dsel < 10) dsel = int'($urandom_range(0, 3));
         cycle(r, s, c, v, dsel);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
